// File: rtl/dp_pkg.sv
// Shared types and defaults for the dot-product execution stage.
// The state encoding is also exposed on the debug/LED port, so its values are fixed.
package dp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dp_state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ACC_WIDTH  = 24;
    localparam int DEF_DEPTH      = 8;

    // Counters must be able to hold the value DEPTH itself, not just DEPTH-1.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dot_product_engine_mac_pipe.sv
// Three-stage unsigned multiply-accumulate: operand capture, multiply, accumulate.
// Each stage carries a valid bit, so bubbles pass through without touching the accumulator.
module mac_pipe
    import dp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int CNT_WIDTH  = count_width(DEF_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  issue,
    input  logic [DATA_WIDTH-1:0] a_q,
    input  logic [DATA_WIDTH-1:0] b_q,
    output logic [ACC_WIDTH-1:0]  acc,
    output logic [CNT_WIDTH-1:0]  acc_count,
    output logic                  acc_fire
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    logic                  issue_d_reg;
    logic                  v1_reg;
    logic                  v2_reg;
    logic [DATA_WIDTH-1:0] op_a_reg;
    logic [DATA_WIDTH-1:0] op_b_reg;
    logic [PROD_WIDTH-1:0] prod_reg;
    logic [ACC_WIDTH-1:0]  acc_reg;
    logic [CNT_WIDTH-1:0]  count_reg;
    logic [PROD_WIDTH-1:0] op_a_ext;
    logic [PROD_WIDTH-1:0] op_b_ext;

    assign op_a_ext = {{DATA_WIDTH{1'b0}}, op_a_reg};
    assign op_b_ext = {{DATA_WIDTH{1'b0}}, op_b_reg};

    // FIFO data lags the pop by one cycle, so issue is delayed to line up with a_q/b_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_d_reg <= 1'b0;
            v1_reg      <= 1'b0;
            v2_reg      <= 1'b0;
            op_a_reg    <= '0;
            op_b_reg    <= '0;
            prod_reg    <= '0;
            acc_reg     <= '0;
            count_reg   <= '0;
        end else if (clear) begin
            issue_d_reg <= 1'b0;
            v1_reg      <= 1'b0;
            v2_reg      <= 1'b0;
            acc_reg     <= '0;
            count_reg   <= '0;
        end else begin
            issue_d_reg <= issue;
            v1_reg      <= issue_d_reg;
            v2_reg      <= v1_reg;
            if (issue_d_reg) begin
                op_a_reg <= a_q;
                op_b_reg <= b_q;
            end
            if (v1_reg) begin
                prod_reg <= op_a_ext * op_b_ext;
            end
            if (v2_reg) begin
                acc_reg   <= acc_reg + ACC_WIDTH'(prod_reg);
                count_reg <= count_reg + CNT_WIDTH'(1);
            end
        end
    end

    assign acc       = acc_reg;
    assign acc_count = count_reg;
    assign acc_fire  = v2_reg;

endmodule

// File: rtl/dot_product_engine.sv
// Pops paired operands from the A/B FIFOs and reports their dot product over DEPTH pairs.
// Holds the control FSM and issue counter; arithmetic lives in mac_pipe.
module dot_product_engine
    import dp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a_q,
    input  logic                  a_empty,
    output logic                  a_rdreq,
    input  logic [DATA_WIDTH-1:0] b_q,
    input  logic                  b_empty,
    output logic                  b_rdreq,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  done,
    output logic                  busy,
    output logic [1:0]            state
);

    localparam int                   CNT_WIDTH = count_width(DEPTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C   = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH_M1  = CNT_WIDTH'(DEPTH - 1);

    dp_state_t             state_reg;
    dp_state_t             state_next;
    logic [CNT_WIDTH-1:0]  issued_reg;
    logic [CNT_WIDTH-1:0]  acc_count;
    logic                  acc_fire;
    logic                  acc_last;
    logic                  start_ok;
    logic                  rd;

    assign start_ok = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

    assign rd = (state_reg == ST_RUN) && !a_empty && !b_empty && (issued_reg < DEPTH_C);

    // Leave DRAIN on the same edge as the final accumulate so result is valid with done.
    assign acc_last = (acc_count == DEPTH_C) || (acc_fire && (acc_count == DEPTH_M1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            issued_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (start_ok) begin
                issued_reg <= '0;
            end else if (rd) begin
                issued_reg <= issued_reg + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (rd && (issued_reg == DEPTH_M1)) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (acc_last) state_next = ST_DONE;
            end
            ST_DONE: begin
                if (start) state_next = ST_RUN;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    mac_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_mac_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_ok),
        .issue     (rd),
        .a_q       (a_q),
        .b_q       (b_q),
        .acc       (result),
        .acc_count (acc_count),
        .acc_fire  (acc_fire)
    );

    assign a_rdreq = rd;
    assign b_rdreq = rd;
    assign done    = (state_reg == ST_DONE);
    assign busy    = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign state   = state_reg;

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed bench for dot_product_engine with behavioural A/B FIFO models.
// Cycle k below is counted from the cycle after start is sampled (k=1 is the first RUN cycle).
module tb_dot_product_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a_q = '0;
    logic [7:0]  b_q = '0;
    logic        a_empty;
    logic        b_empty;
    logic        a_rdreq;
    logic        b_rdreq;
    logic [23:0] result;
    logic        done;
    logic        busy;
    logic [1:0]  state;

    logic        w_start = 1'b0;
    logic [7:0]  w_q = 8'hFF;
    logic        w_empty = 1'b0;
    logic        w_a_rdreq;
    logic        w_b_rdreq;
    logic [15:0] w_result;
    logic        w_done;
    logic        w_busy;
    logic [1:0]  w_state;

    always #5 clk = ~clk;

    dot_product_engine dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_q     (a_q),
        .a_empty (a_empty),
        .a_rdreq (a_rdreq),
        .b_q     (b_q),
        .b_empty (b_empty),
        .b_rdreq (b_rdreq),
        .result  (result),
        .done    (done),
        .busy    (busy),
        .state   (state)
    );

    dot_product_engine #(.ACC_WIDTH(16)) dut_wrap (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_start),
        .a_q     (w_q),
        .a_empty (w_empty),
        .a_rdreq (w_a_rdreq),
        .b_q     (w_q),
        .b_empty (w_empty),
        .b_rdreq (w_b_rdreq),
        .result  (w_result),
        .done    (w_done),
        .busy    (w_busy),
        .state   (w_state)
    );

    // FIFO models: memories and write pointers owned by the initial block, read side by this always.
    logic [7:0] a_mem [64];
    logic [7:0] b_mem [64];
    int a_rd = 0, a_wr = 0, b_rd = 0, b_wr = 0;
    int pop_total = 0;
    int stall_at = 0;
    int stall_cnt = 0;
    logic pop_empty_err = 1'b0;
    logic pair_err = 1'b0;

    assign a_empty = (a_rd == a_wr);
    assign b_empty = (b_rd == b_wr) || (stall_cnt != 0);

    always @(posedge clk) begin
        if (a_rdreq) begin
            if (a_empty) pop_empty_err <= 1'b1;
            a_q  <= a_mem[a_rd % 64];
            a_rd <= a_rd + 1;
        end
        if (b_rdreq) begin
            if (b_empty) pop_empty_err <= 1'b1;
            b_q       <= b_mem[b_rd % 64];
            b_rd      <= b_rd + 1;
            pop_total <= pop_total + 1;
        end
        if (a_rdreq !== b_rdreq) pair_err <= 1'b1;
        if (b_rdreq && (pop_total + 1 == stall_at)) stall_cnt <= 3;
        else if (stall_cnt != 0) stall_cnt <= stall_cnt - 1;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic load(input int a0, input int astep, input int b0, input int bstep);
        for (int i = 0; i < 8; i++) begin
            a_mem[a_wr % 64] = 8'(a0 + i * astep);
            b_mem[b_wr % 64] = 8'(b0 + i * bstep);
            a_wr++;
            b_wr++;
        end
    endtask

    int r_first, r_last, r_done, r_pops, r_res_k1;

    task automatic run_engine(input int extra_start_k, input int abort_pops);
        r_first  = -1;
        r_last   = -1;
        r_done   = -1;
        r_pops   = 0;
        r_res_k1 = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start = (k == extra_start_k);
            if (k == 1) r_res_k1 = int'(result);
            if (abort_pops > 0 && r_pops == abort_pops) begin
                rst_n = 1'b0;
                break;
            end
            if (a_rdreq) begin
                r_pops++;
                if (r_first < 0) r_first = k;
                r_last = k;
            end
            if (done) begin
                r_done = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    int idle_pops;
    int w_pops;
    int w_done_seen;

    initial begin
        // Reset with non-empty FIFOs and no start
        load(0, 5, 0, 10);
        repeat (3) @(negedge clk);
        check("rst_result", result, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_state", state, 0);
        check("rst_a_rdreq", a_rdreq, 0);
        check("rst_b_rdreq", b_rdreq, 0);
        check("rst_wrap_result", w_result, 0);
        rst_n = 1'b1;
        idle_pops = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (a_rdreq || b_rdreq) idle_pops++;
        end
        check("idle_pops", idle_pops, 0);
        check("idle_state", state, 0);

        // Nominal run: sum of (5i)*(10i) for i=0..7 = 50*140
        run_engine(0, 0);
        check("nom_first_rd", r_first, 1);
        check("nom_last_rd", r_last, 8);
        check("nom_pops", r_pops, 8);
        check("nom_done_cycle", r_done, 12);
        check("nom_result", result, 7000);
        check("nom_state", state, 3);
        check("nom_busy", busy, 0);

        // B stalls for 3 cycles after the 4th pop
        load(0, 5, 0, 10);
        stall_at = pop_total + 4;
        run_engine(0, 0);
        stall_at = 0;
        check("stall_pops", r_pops, 8);
        check("stall_last_rd", r_last, 11);
        check("stall_done_cycle", r_done, 15);
        check("stall_result", result, 7000);

        // Start pulse mid-RUN is ignored
        load(0, 5, 0, 10);
        run_engine(3, 0);
        check("ign_pops", r_pops, 8);
        check("ign_done_cycle", r_done, 12);
        check("ign_result", result, 7000);

        // Restart from DONE with A=B=1
        load(1, 0, 1, 0);
        run_engine(0, 0);
        check("restart_result_k1", r_res_k1, 0);
        check("restart_result", result, 8);
        check("restart_done_cycle", r_done, 12);

        // Reset after 3 pops, then a fresh run on refilled FIFOs
        load(0, 5, 0, 10);
        run_engine(0, 3);
        #1;
        check("abort_rdreq", a_rdreq, 0);
        check("abort_state", state, 0);
        check("abort_result", result, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        a_wr = a_rd;
        b_wr = b_rd;
        load(0, 5, 0, 10);
        run_engine(0, 0);
        check("refill_pops", r_pops, 8);
        check("refill_done_cycle", r_done, 12);
        check("refill_result", result, 7000);

        // 16-bit accumulator wraps: 8 * 255 * 255 mod 2^16
        @(negedge clk);
        w_start = 1'b1;
        @(posedge clk);
        w_pops = 0;
        w_done_seen = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            w_start = 1'b0;
            if (w_a_rdreq) w_pops++;
            if (w_done) begin
                w_done_seen = 1;
                break;
            end
        end
        check("wrap_done_seen", w_done_seen, 1);
        check("wrap_pops", w_pops, 8);
        check("wrap_result", w_result, (8 * 255 * 255) % 65536);

        check("never_pop_empty", pop_empty_err, 0);
        check("rdreq_paired", pair_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
